limb_add_seq: RTL and testbench

- Multi-word add/subtract sequencer. Produces one 8*WORDS-bit result by time-sharing one 8-bit ripple/CLA adder slice over WORDS consecutive cycles.
- Registers the inter-limb carry and steps through the limbs, LSB limb first.
- Wraps each operation in valid/ready handshakes. Sits between an operand source (register file / control unit) and the result consumer.

---
 rtl/limb_add_seq_pkg.sv | 8 +
 rtl/limb_add_seq_if.sv | 19 +
 rtl/limb_add_seq_add8_slice.sv | 10 +
 rtl/limb_add_seq.sv | 70 +++++++
 tb/tb_limb_add_seq.sv | 223 ++++++++++++++++++++++
 5 files changed

// File: rtl/limb_add_seq_pkg.sv
// limb_add_seq_pkg: shared limb width, sequencer states and counter sizing
package limb_add_seq_pkg;
    localparam int LIMB_W = 8;
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    function automatic int cnt_w(input int words);
        return (words > 1) ? $clog2(words) : 1;
    endfunction
endpackage

// File: rtl/limb_add_seq_if.sv
// limb_add_seq_if: request/result handshake bundle for the limb sequencer
interface limb_add_seq_if import limb_add_seq_pkg::*; #(parameter int WORDS = 4) ();
    localparam int W = LIMB_W * WORDS;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         sub;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
    modport master (output in_valid, a, b, cin, sub, out_ready,
                    input  in_ready, out_valid, sum, cout, ovf);
    modport slave  (input  in_valid, a, b, cin, sub, out_ready,
                    output in_ready, out_valid, sum, cout, ovf);
endinterface

// File: rtl/limb_add_seq_add8_slice.sv
// add8_slice: one limb-wide adder with carry in and carry out
module add8_slice import limb_add_seq_pkg::*; (
    input  logic [LIMB_W-1:0] x,
    input  logic [LIMB_W-1:0] y,
    input  logic              ci,
    output logic [LIMB_W-1:0] s,
    output logic              co
);
    assign {co, s} = x + y + {{(LIMB_W-1){1'b0}}, ci};
endmodule

// File: rtl/limb_add_seq.sv
// limb_add_seq: multi-limb add/subtract by time-sharing one 8-bit adder slice
module limb_add_seq import limb_add_seq_pkg::*; #(parameter int WORDS = 4) (
    input logic            clk,
    input logic            rst,
    limb_add_seq_if.slave  bus
);
    localparam int W  = LIMB_W * WORDS;
    localparam int CW = cnt_w(WORDS);
    localparam logic [CW-1:0] LAST = CW'(WORDS - 1);
    state_t            state;
    logic [W-1:0]      a_q, b_q, sum_q;
    logic [CW-1:0]     cnt;
    logic              carry, cout_q, ovf_q, in_ready_q, out_valid_q;
    logic [LIMB_W-1:0] s;
    logic              co;
    add8_slice u_slice (
        .x  (a_q[LIMB_W*cnt +: LIMB_W]),
        .y  (b_q[LIMB_W*cnt +: LIMB_W]),
        .ci (carry),
        .s  (s),
        .co (co)
    );
    // Sequencer: latch operands, walk limbs LSB first, hold result until taken
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            cnt         <= '0;
            carry       <= 1'b0;
            sum_q       <= '0;
            cout_q      <= 1'b0;
            ovf_q       <= 1'b0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
        end else begin
            case (state)
                IDLE: if (bus.in_valid) begin
                    a_q        <= bus.a;
                    b_q        <= bus.sub ? ~bus.b : bus.b;
                    carry      <= bus.sub | bus.cin;
                    cnt        <= '0;
                    in_ready_q <= 1'b0;
                    state      <= RUN;
                end
                RUN: begin
                    sum_q[LIMB_W*cnt +: LIMB_W] <= s;
                    carry <= co;
                    if (cnt == LAST) begin
                        cout_q      <= co;
                        ovf_q       <= (a_q[W-1] == b_q[W-1]) && (s[LIMB_W-1] != a_q[W-1]);
                        out_valid_q <= 1'b1;
                        state       <= DONE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DONE: if (bus.out_ready) begin
                    out_valid_q <= 1'b0;
                    in_ready_q  <= 1'b1;
                    state       <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.sum       = sum_q;
    assign bus.cout      = cout_q;
    assign bus.ovf       = ovf_q;
endmodule

// File: tb/tb_limb_add_seq.sv
// tb_limb_add_seq: directed scoreboard bench for the limb add/subtract sequencer
module tb_limb_add_seq;
    typedef struct packed {
        logic [31:0] sum;
        logic        cout;
        logic        ovf;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad = 0;
    exp_t sb[$];

    always #5 clk = ~clk;

    limb_add_seq_if #(.WORDS(4)) bus ();
    limb_add_seq_if #(.WORDS(2)) bus2 ();

    limb_add_seq #(.WORDS(4)) dut (.clk(clk), .rst(rst), .bus(bus));
    limb_add_seq #(.WORDS(2)) dut2 (.clk(clk), .rst(rst), .bus(bus2));

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic exp_t model(input logic [31:0] a, input logic [31:0] b,
                                   input logic cin, input logic sub);
        logic [31:0] bx;
        logic [32:0] r;
        exp_t e;
        bx = sub ? ~b : b;
        r = {1'b0, a} + {1'b0, bx} + {32'd0, sub ? 1'b1 : cin};
        e.sum  = r[31:0];
        e.cout = r[32];
        e.ovf  = (a[31] == bx[31]) && (r[31] != a[31]);
        return e;
    endfunction

    task automatic send(input logic [31:0] a, input logic [31:0] b,
                        input logic cin, input logic sub);
        int n = 0;
        bus.in_valid = 1'b1;
        bus.a = a;
        bus.b = b;
        bus.cin = cin;
        bus.sub = sub;
        while (!bus.in_ready && n < 50) begin
            tick();
            n++;
        end
        if (n >= 50) chk("accept_timeout", 64'(n), 64'(0));
        sb.push_back(model(a, b, cin, sub));
        tick();
        bus.in_valid = 1'b0;
        bus.a = $urandom;
        bus.b = $urandom;
        bus.cin = 1'($urandom);
        bus.sub = 1'($urandom);
    endtask

    task automatic check_out(input string tag);
        exp_t e;
        if (sb.size() == 0) begin
            chk({tag, "_sb_empty"}, 64'(0), 64'(1));
        end else begin
            e = sb.pop_front();
            chk({tag, "_sum"}, 64'(bus.sum), 64'(e.sum));
            chk({tag, "_cout"}, 64'(bus.cout), 64'(e.cout));
            chk({tag, "_ovf"}, 64'(bus.ovf), 64'(e.ovf));
        end
    endtask

    task automatic recv(input string tag, input int hold);
        int n = 0;
        logic [31:0] s0;
        while (!bus.out_valid && n < 50) begin
            tick();
            n++;
        end
        chk({tag, "_latency"}, 64'(n), 64'(4));
        check_out(tag);
        s0 = bus.sum;
        for (int i = 0; i < hold; i++) begin
            bus.in_valid = 1'b1;
            bus.a = $urandom;
            bus.b = $urandom;
            tick();
            chk({tag, "_hold_sum"}, 64'(bus.sum), 64'(s0));
            chk({tag, "_hold_valid"}, 64'(bus.out_valid), 64'(1));
            chk({tag, "_hold_ready"}, 64'(bus.in_ready), 64'(0));
        end
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        chk({tag, "_post_valid"}, 64'(bus.out_valid), 64'(0));
        chk({tag, "_post_ready"}, 64'(bus.in_ready), 64'(1));
        chk({tag, "_post_sum_kept"}, 64'(bus.sum), 64'(s0));
    endtask

    initial begin
        int acc[$];
        int c;
        int idx;
        int done_n;
        int n;
        logic [31:0] ops_a[3] = '{32'h1111_1111, 32'h8000_0000, 32'h0000_00FF};
        logic [31:0] ops_b[3] = '{32'h2222_2222, 32'h0000_0001, 32'h0000_0001};
        logic        ops_s[3] = '{1'b0, 1'b1, 1'b0};
        bus.in_valid = 1'b0; bus.a = '0; bus.b = '0; bus.cin = 1'b0; bus.sub = 1'b0;
        bus.out_ready = 1'b0;
        bus2.in_valid = 1'b0; bus2.a = '0; bus2.b = '0; bus2.cin = 1'b0; bus2.sub = 1'b0;
        bus2.out_ready = 1'b0;
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        chk("rst_in_ready", 64'(bus.in_ready), 64'(1));
        chk("rst_out_valid", 64'(bus.out_valid), 64'(0));
        chk("rst_sum", 64'(bus.sum), 64'(0));
        chk("rst_cout", 64'(bus.cout), 64'(0));
        chk("rst_ovf", 64'(bus.ovf), 64'(0));

        send(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0);
        recv("wrap", 0);
        send(32'h0000_0005, 32'h0000_0007, 1'b0, 1'b1);
        recv("sub5m7", 0);
        send(32'h0000_0007, 32'h0000_0005, 1'b1, 1'b1);
        recv("sub7m5", 0);
        send(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0);
        recv("ovf_add", 0);
        send(32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1);
        recv("ovf_sub", 0);
        send(32'h00FF_00FF, 32'h0001_0001, 1'b1, 1'b0);
        recv("chain_hold", 3);

        send(32'h1234_5678, 32'h0000_0001, 1'b0, 1'b0);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        sb.delete();
        chk("midrun_rst_in_ready", 64'(bus.in_ready), 64'(1));
        chk("midrun_rst_out_valid", 64'(bus.out_valid), 64'(0));
        chk("midrun_rst_sum", 64'(bus.sum), 64'(0));
        for (int i = 0; i < 6; i++) begin
            tick();
            chk("midrun_rst_quiet", 64'(bus.out_valid), 64'(0));
        end
        send(32'h0000_0010, 32'h0000_0020, 1'b0, 1'b0);
        recv("after_rst", 0);

        c = 0; idx = 0; done_n = 0;
        bus.out_ready = 1'b1;
        bus.in_valid = 1'b1;
        bus.a = ops_a[0]; bus.b = ops_b[0]; bus.cin = 1'b0; bus.sub = ops_s[0];
        while (done_n < 3 && c < 80) begin
            logic took;
            took = 1'b0;
            if (bus.out_valid) begin
                check_out("b2b");
                done_n++;
            end
            if (bus.in_ready && bus.in_valid) begin
                sb.push_back(model(bus.a, bus.b, bus.cin, bus.sub));
                acc.push_back(c);
                idx++;
                took = 1'b1;
            end
            tick();
            c++;
            if (took) begin
                if (idx < 3) begin
                    bus.a = ops_a[idx]; bus.b = ops_b[idx]; bus.sub = ops_s[idx];
                end else begin
                    bus.in_valid = 1'b0;
                end
            end
        end
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b0;
        chk("b2b_done", 64'(done_n), 64'(3));
        chk("b2b_accepts", 64'(acc.size()), 64'(3));
        if (acc.size() == 3) begin
            chk("b2b_period01", 64'(acc[1] - acc[0]), 64'(6));
            chk("b2b_period12", 64'(acc[2] - acc[1]), 64'(6));
        end

        bus2.in_valid = 1'b1;
        bus2.a = 16'hFFFF;
        bus2.b = 16'h0001;
        chk("w2_in_ready", 64'(bus2.in_ready), 64'(1));
        tick();
        bus2.in_valid = 1'b0;
        bus2.a = 16'h1234;
        n = 0;
        while (!bus2.out_valid && n < 50) begin
            tick();
            n++;
        end
        chk("w2_latency", 64'(n), 64'(2));
        chk("w2_sum", 64'(bus2.sum), 64'(16'h0000));
        chk("w2_cout", 64'(bus2.cout), 64'(1));
        chk("w2_ovf", 64'(bus2.ovf), 64'(0));
        bus2.out_ready = 1'b1;
        tick();
        bus2.out_ready = 1'b0;
        chk("w2_post_valid", 64'(bus2.out_valid), 64'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
